// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a local Fibonacci LFSR to the incoming bit stream,
// then flywheels on its own prediction, flagging and counting every mismatching bit.
module prbs_checker #(
  parameter int unsigned    N          = 8,
  parameter logic [N-1:0]   TAPS       = 8'b00000011,
  parameter int unsigned    LOCK_COUNT = 16,
  parameter int unsigned    WINDOW     = 64,
  parameter int unsigned    ERR_LIMIT  = 4,
  parameter int unsigned    COUNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               data_i,
  input  logic               valid_i,
  input  logic               clear_i,
  output logic               locked_o,
  output logic               err_o,
  output logic [COUNT_W-1:0] bit_count_o,
  output logic [COUNT_W-1:0] err_count_o
);

  localparam int unsigned FillW  = $clog2(N + 1);
  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WinW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned WerrW  = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {StFill, StHunt, StLock} state_e;

  state_e             r_state;
  logic [N-1:0]       r_hist;
  logic [FillW-1:0]   r_fill_cnt;
  logic [MatchW-1:0]  r_match_cnt;
  logic [WinW-1:0]    r_win_cnt;
  logic [WerrW-1:0]   r_win_err;
  logic [COUNT_W-1:0] r_bit_cnt;
  logic [COUNT_W-1:0] r_err_cnt;
  logic               r_locked;
  logic               r_err;

  logic               w_pred;
  logic               w_match;
  logic [WerrW-1:0]   w_win_err_inc;
  logic               w_lose_lock;
  logic               w_win_last;

  // h[0] is the oldest bit, so tap i weights the bit i positions after it.
  assign w_pred        = ^(r_hist & TAPS);
  assign w_match       = (data_i == w_pred);
  assign w_win_err_inc = r_win_err + WerrW'(1);
  assign w_lose_lock   = !w_match && (w_win_err_inc == WerrW'(ERR_LIMIT));
  assign w_win_last    = (r_win_cnt == WinW'(WINDOW - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= StFill;
      r_hist      <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_bit_cnt   <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (valid_i) begin
        unique case (r_state)
          StFill: begin
            r_hist <= {data_i, r_hist[N-1:1]};
            if (r_fill_cnt == FillW'(N - 1)) begin
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
              r_state     <= StHunt;
            end else begin
              r_fill_cnt <= r_fill_cnt + FillW'(1);
            end
          end

          StHunt: begin
            r_hist <= {data_i, r_hist[N-1:1]};
            if (!w_match) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == MatchW'(LOCK_COUNT - 1)) begin
              r_match_cnt <= '0;
              r_win_cnt   <= '0;
              r_win_err   <= '0;
              r_locked    <= 1'b1;
              r_state     <= StLock;
            end else begin
              r_match_cnt <= r_match_cnt + MatchW'(1);
            end
          end

          StLock: begin
            // Flywheel on the prediction so a channel error never corrupts the history.
            r_hist <= {w_pred, r_hist[N-1:1]};
            if (r_bit_cnt != '1) begin
              r_bit_cnt <= r_bit_cnt + COUNT_W'(1);
            end
            if (!w_match) begin
              r_err <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + COUNT_W'(1);
              end
            end
            if (w_lose_lock) begin
              r_hist      <= '0;
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
              r_win_cnt   <= '0;
              r_win_err   <= '0;
              r_locked    <= 1'b0;
              r_state     <= StFill;
            end else if (w_win_last) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WinW'(1);
              if (!w_match) begin
                r_win_err <= w_win_err_inc;
              end
            end
          end

          default: r_state <= StFill;
        endcase
      end

      if (clear_i) begin
        r_bit_cnt <= '0;
        r_err_cnt <= '0;
      end
    end
  end

  assign locked_o    = r_locked;
  assign err_o       = r_err;
  assign bit_count_o = r_bit_cnt;
  assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed segment table plus randomized traffic, both checked
// every cycle against a queue-based reference model (one full-width and one 4-bit DUT).
module tb_prbs_checker;

  localparam int unsigned N          = 8;
  localparam logic [7:0]  TAPS       = 8'b00000011;
  localparam logic [7:0]  START      = 8'b00000001;
  localparam int unsigned LOCK_COUNT = 16;
  localparam int unsigned WINDOW     = 64;
  localparam int unsigned ERR_LIMIT  = 4;
  localparam int          SEQ_LEN    = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked_a, err_a, locked_b, err_b;
  logic [31:0] bits_a, errs_a;
  logic [3:0]  bits_b, errs_b;

  always #5 clk = ~clk;

  prbs_checker #(.N(N), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
                 .ERR_LIMIT(ERR_LIMIT), .COUNT_W(32)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .data_i(data), .valid_i(valid), .clear_i(clear),
    .locked_o(locked_a), .err_o(err_a), .bit_count_o(bits_a), .err_count_o(errs_a)
  );

  prbs_checker #(.N(N), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
                 .ERR_LIMIT(ERR_LIMIT), .COUNT_W(4)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .data_i(data), .valid_i(valid), .clear_i(clear),
    .locked_o(locked_b), .err_o(err_b), .bit_count_o(bits_b), .err_count_o(errs_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  bit seq[SEQ_LEN];
  int gidx = 0;

  // Reference model state: history as a queue of bits, oldest at the front.
  bit     m_hq[$];
  bit     m_lock = 1'b0;
  bit     m_err  = 1'b0;
  int     m_run  = 0;
  longint m_lockpos = 0;
  longint m_curwin  = 0;
  int     m_werr    = 0;
  longint m_bits    = 0;
  longint m_errs    = 0;

  function automatic bit next_bit();
    bit b = seq[gidx];
    gidx++;
    return b;
  endfunction

  function automatic bit predict();
    logic [7:0] taps = TAPS;
    bit x = 1'b0;
    for (int i = 0; i < int'(N); i++) x ^= m_hq[i] & taps[i];
    return x;
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_step(bit r, bit v, bit d, bit c);
    bit p;
    if (r) begin
      m_hq.delete();
      m_lock = 1'b0; m_err = 1'b0; m_run = 0; m_bits = 0; m_errs = 0;
      return;
    end
    m_err = 1'b0;
    if (v) begin
      if (!m_lock && m_hq.size() < int'(N)) begin
        m_hq.push_back(d);
      end else if (!m_lock) begin
        p = predict();
        m_run = (d == p) ? m_run + 1 : 0;
        m_hq.push_back(d);
        void'(m_hq.pop_front());
        if (m_run == int'(LOCK_COUNT)) begin
          m_lock = 1'b1; m_run = 0; m_lockpos = 0; m_curwin = 0; m_werr = 0;
        end
      end else begin
        p = predict();
        if (m_lockpos / WINDOW != m_curwin) begin
          m_curwin = m_lockpos / WINDOW;
          m_werr   = 0;
        end
        m_lockpos++;
        m_bits++;
        m_hq.push_back(p);
        void'(m_hq.pop_front());
        if (d != p) begin
          m_err = 1'b1;
          m_errs++;
          m_werr++;
          if (m_werr == int'(ERR_LIMIT)) begin
            m_lock = 1'b0;
            m_hq.delete();
          end
        end
      end
    end
    if (c) begin
      m_bits = 0;
      m_errs = 0;
    end
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit v, bit d, bit c, bit r);
    valid = v; data = d; clear = c; reset = r;
    @(posedge clk);
    model_step(r, v, d, c);
    #1;
    chk("locked",       longint'(locked_a), longint'(m_lock));
    chk("err",          longint'(err_a),    longint'(m_err));
    chk("bit_count",    longint'(bits_a),   sat(m_bits, 32));
    chk("err_count",    longint'(errs_a),   sat(m_errs, 32));
    chk("locked_w4",    longint'(locked_b), longint'(m_lock));
    chk("err_w4",       longint'(err_b),    longint'(m_err));
    chk("bit_count_w4", longint'(bits_b),   sat(m_bits, 4));
    chk("err_count_w4", longint'(errs_b),   sat(m_errs, 4));
  endtask

  typedef struct {
    bit          rst;
    int          nbits;
    int          gap;
    logic [63:0] flips;
    bit          clr_last;
    bit          exp_locked;
    longint      exp_bits;
    longint      exp_errs;
  } seg_t;

  seg_t segs[19];

  initial begin
    logic [7:0] st = START;
    logic [7:0] tp = TAPS;
    bit x;
    bit v, d, c, r;

    for (int k = 0; k < SEQ_LEN; k++) begin
      if (k < int'(N)) begin
        seq[k] = st[k];
      end else begin
        x = 1'b0;
        for (int i = 0; i < int'(N); i++) x ^= tp[i] & seq[k - int'(N) + i];
        seq[k] = x;
      end
    end

    //          rst nbits gap flips          clr lock bits errs
    segs[0]  = '{1, 23, 0, 64'h0,           0, 0, 0,  0}; // fill + hunt, not yet locked
    segs[1]  = '{0, 1,  0, 64'h0,           0, 1, 0,  0}; // 24th bit -> lock
    segs[2]  = '{0, 10, 0, 64'h0,           0, 1, 10, 0};
    segs[3]  = '{0, 5,  0, 64'h4,           0, 1, 15, 1}; // single error
    segs[4]  = '{0, 8,  0, 64'h15,          0, 0, 20, 4}; // 4th error in window -> unlock
    segs[5]  = '{0, 20, 0, 64'h0,           0, 0, 20, 4};
    segs[6]  = '{0, 1,  0, 64'h0,           0, 1, 20, 4}; // relock 24 bits after loss
    segs[7]  = '{0, 60, 0, 64'h0,           0, 1, 80, 4};
    segs[8]  = '{0, 3,  0, 64'h7,           0, 1, 83, 7}; // window bits 60..62
    segs[9]  = '{0, 3,  0, 64'h4,           0, 1, 86, 8}; // bit 1 of next window
    segs[10] = '{0, 1,  0, 64'h1,           1, 1, 0,  0}; // clear beats error
    segs[11] = '{0, 4,  0, 64'h0,           0, 1, 4,  0};
    segs[12] = '{1, 0,  0, 64'h0,           0, 0, 0,  0}; // reset mid-lock
    segs[13] = '{0, 23, 2, 64'h0,           0, 0, 0,  0}; // 1-on/2-off gaps
    segs[14] = '{0, 1,  2, 64'h0,           0, 1, 0,  0};
    segs[15] = '{0, 5,  2, 64'h0,           0, 1, 5,  0};
    segs[16] = '{1, 43, 0, 64'h1 << 19,     0, 0, 0,  0}; // junk at valid bit 20
    segs[17] = '{0, 1,  0, 64'h0,           0, 1, 0,  0}; // 16 matches after bits 27,28
    segs[18] = '{0, 3,  0, 64'h0,           0, 1, 3,  0};

    for (int s = 0; s < 19; s++) begin
      if (segs[s].rst) tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 0; b < segs[s].nbits; b++) begin
        tick(1'b1, next_bit() ^ segs[s].flips[b],
             segs[s].clr_last && (b == segs[s].nbits - 1), 1'b0);
        for (int g = 0; g < segs[s].gap; g++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk($sformatf("seg%0d_locked", s), longint'(locked_a), longint'(segs[s].exp_locked));
      chk($sformatf("seg%0d_bits", s),   longint'(bits_a),   segs[s].exp_bits);
      chk($sformatf("seg%0d_errs", s),   longint'(errs_a),   segs[s].exp_errs);
      chk($sformatf("seg%0d_bits_w4", s), longint'(bits_b),  sat(segs[s].exp_bits, 4));
    end

    // Randomized traffic: gaps, sparse channel errors, occasional clear and reset.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom % 4) != 0;
      d = v ? (next_bit() ^ (($urandom % 40) == 0)) : bit'($urandom % 2);
      c = ($urandom % 200) == 0;
      r = ($urandom % 1500) == 0;
      tick(v, d, c, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
